// File: rtl/thread_fetch_sched.sv
// rtl/thread_fetch_sched.sv - four-thread round-robin fetch scheduler ahead of IF/ID
module thread_fetch_sched #(
  parameter int INSTMEM_LOG2_DEEP = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [3:0]                   i_thread_en,
  input  logic                         i_hazard,
  input  logic                         i_redirect_valid,
  input  logic [1:0]                   i_redirect_tid,
  input  logic [INSTMEM_LOG2_DEEP-1:0] i_redirect_pc,
  input  logic                         i_halt_valid,
  input  logic [1:0]                   i_halt_tid,
  output logic [INSTMEM_LOG2_DEEP-1:0] o_fetch_pc,
  output logic [1:0]                   o_fetch_tid,
  output logic                         o_fetch_valid,
  output logic                         o_all_done
);

  localparam int W           = INSTMEM_LOG2_DEEP;
  localparam int NUM_THREADS = 4;

  // Per-thread architectural state.
  logic [W-1:0] r_pc [NUM_THREADS];
  logic [3:0]   r_halted;
  logic [1:0]   r_last_tid;

  // Combinational scheduling decisions.
  logic [3:0]   w_elig;
  logic         w_found;
  logic [1:0]   w_sel;
  logic         w_issue;
  logic         w_bypass;
  logic [W-1:0] w_issue_pc;
  logic [W-1:0] w_next_pc;

  // A thread may be picked when enabled, not halted, and not being halted right now.
  always_comb begin
    w_elig = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      w_elig[t] = i_thread_en[t] & ~r_halted[t]
                & ~(i_halt_valid && (i_halt_tid == 2'(t)));
    end
  end

  // Round-robin pick: scan from the thread after last_tid, wrapping back to last_tid itself.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_last_tid;
    for (int k = 1; k <= NUM_THREADS; k++) begin
      if (!w_found && w_elig[r_last_tid + 2'(k)]) begin
        w_found = 1'b1;
        w_sel   = r_last_tid + 2'(k);
      end
    end
  end

  // Issued PC: a same-cycle redirect of the selected thread is forwarded so no bubble appears.
  always_comb begin
    w_issue    = ~i_hazard & w_found;
    w_bypass   = i_redirect_valid && (i_redirect_tid == w_sel);
    w_issue_pc = w_bypass ? i_redirect_pc : r_pc[w_sel];
    w_next_pc  = w_issue_pc + 1'b1;
  end

  // PC file: issued thread advances past its fetch; otherwise a redirect loads the target.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        r_pc[t] <= {2'(t), {(W-2){1'b0}}};
      end
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (w_issue && (w_sel == 2'(t))) begin
          r_pc[t] <= w_next_pc;
        end else if (i_redirect_valid && (i_redirect_tid == 2'(t))) begin
          r_pc[t] <= i_redirect_pc;
        end
      end
    end
  end

  // Halt flags are sticky until reset and are recorded even while stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_halted <= '0;
    end else if (i_halt_valid) begin
      r_halted[i_halt_tid] <= 1'b1;
    end
  end

  // Fetch outputs and round-robin pointer; a stall freezes all of them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last_tid    <= 2'd3;
      o_fetch_pc    <= '0;
      o_fetch_tid   <= '0;
      o_fetch_valid <= 1'b0;
    end else if (!i_hazard) begin
      if (w_found) begin
        r_last_tid    <= w_sel;
        o_fetch_pc    <= w_issue_pc;
        o_fetch_tid   <= w_sel;
        o_fetch_valid <= 1'b1;
      end else begin
        o_fetch_valid <= 1'b0;
      end
    end
  end

  // Completion flag: every enabled thread has halted (or nothing is enabled).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_all_done <= 1'b0;
    end else begin
      o_all_done <= &(r_halted | ~i_thread_en);
    end
  end

endmodule

// File: tb/tb_thread_fetch_sched.sv
// tb/tb_thread_fetch_sched.sv - vector-table and scoreboard bench for thread_fetch_sched
module tb_thread_fetch_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] thread_en;
  logic       hazard;
  logic       redirect_valid;
  logic [1:0] redirect_tid;
  logic [7:0] redirect_pc;
  logic       halt_valid;
  logic [1:0] halt_tid;
  logic [7:0] fetch_pc;
  logic [1:0] fetch_tid;
  logic       fetch_valid;
  logic       all_done;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0] en;
    logic       hz;
    logic       rv;
    logic [1:0] rtid;
    logic [7:0] rpc;
    logic       hv;
    logic [1:0] htid;
    logic       ev;
    logic [1:0] etid;
    logic [7:0] epc;
    logic       edone;
  } vec_t;

  vec_t seq1[$];
  vec_t seq2[$];
  vec_t sb[$];

  thread_fetch_sched #(.INSTMEM_LOG2_DEEP(8)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_thread_en      (thread_en),
    .i_hazard         (hazard),
    .i_redirect_valid (redirect_valid),
    .i_redirect_tid   (redirect_tid),
    .i_redirect_pc    (redirect_pc),
    .i_halt_valid     (halt_valid),
    .i_halt_tid       (halt_tid),
    .o_fetch_pc       (fetch_pc),
    .o_fetch_tid      (fetch_tid),
    .o_fetch_valid    (fetch_valid),
    .o_all_done       (all_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] en, input logic hz,
                              input logic rv, input logic [1:0] rtid, input logic [7:0] rpc,
                              input logic hv, input logic [1:0] htid,
                              input logic ev, input logic [1:0] etid, input logic [7:0] epc,
                              input logic edone);
    vec_t v;
    v.en = en; v.hz = hz; v.rv = rv; v.rtid = rtid; v.rpc = rpc;
    v.hv = hv; v.htid = htid; v.ev = ev; v.etid = etid; v.epc = epc; v.edone = edone;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    thread_en      = v.en;
    hazard         = v.hz;
    redirect_valid = v.rv;
    redirect_tid   = v.rtid;
    redirect_pc    = v.rpc;
    halt_valid     = v.hv;
    halt_tid       = v.htid;
    sb.push_back(v);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk($sformatf("v%0d.valid", idx), 32'(fetch_valid), 32'(e.ev));
    chk($sformatf("v%0d.tid", idx),   32'(fetch_tid),   32'(e.etid));
    chk($sformatf("v%0d.pc", idx),    32'(fetch_pc),    32'(e.epc));
    chk($sformatf("v%0d.done", idx),  32'(all_done),    32'(e.edone));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Round-robin, stall with redirect, bypassed redirect, halts down to all_done.
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 0,0, 1,0,8'h00, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 0,0, 1,1,8'h40, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 0,0, 1,2,8'h80, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 0,0, 1,3,8'hC0, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 0,0, 1,0,8'h01, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 0,0, 1,1,8'h41, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 0,0, 1,2,8'h81, 0));
    seq1.push_back(mk(4'hF,1, 0,0,8'h00, 0,0, 1,2,8'h81, 0));
    seq1.push_back(mk(4'hF,1, 1,1,8'h20, 0,0, 1,2,8'h81, 0));
    seq1.push_back(mk(4'hF,1, 0,0,8'h00, 0,0, 1,2,8'h81, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 0,0, 1,3,8'hC1, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 0,0, 1,0,8'h02, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 0,0, 1,1,8'h20, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 0,0, 1,2,8'h82, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 0,0, 1,3,8'hC2, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 0,0, 1,0,8'h03, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 0,0, 1,1,8'h21, 0));
    seq1.push_back(mk(4'hF,0, 1,2,8'h50, 0,0, 1,2,8'h50, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 0,0, 1,3,8'hC3, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 0,0, 1,0,8'h04, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 0,0, 1,1,8'h22, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 0,0, 1,2,8'h51, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 1,3, 1,0,8'h05, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 0,0, 1,1,8'h23, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 0,0, 1,2,8'h52, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 0,0, 1,0,8'h06, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 1,0, 1,1,8'h24, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 1,1, 1,2,8'h53, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 1,2, 0,2,8'h53, 0));
    seq1.push_back(mk(4'hF,0, 0,0,8'h00, 0,0, 0,2,8'h53, 1));

    // After mid-run reset: masked threads, disable/re-enable, PC wrap, single-thread stall.
    seq2.push_back(mk(4'h5,0, 0,0,8'h00, 0,0, 1,0,8'h00, 0));
    seq2.push_back(mk(4'h5,0, 0,0,8'h00, 0,0, 1,2,8'h80, 0));
    seq2.push_back(mk(4'h5,0, 0,0,8'h00, 0,0, 1,0,8'h01, 0));
    seq2.push_back(mk(4'h5,0, 0,0,8'h00, 0,0, 1,2,8'h81, 0));
    seq2.push_back(mk(4'h0,0, 0,0,8'h00, 0,0, 0,2,8'h81, 1));
    seq2.push_back(mk(4'h1,0, 0,0,8'h00, 0,0, 1,0,8'h02, 0));
    seq2.push_back(mk(4'h1,0, 1,0,8'hFF, 0,0, 1,0,8'hFF, 0));
    seq2.push_back(mk(4'h1,0, 0,0,8'h00, 0,0, 1,0,8'h00, 0));
    seq2.push_back(mk(4'h1,1, 0,0,8'h00, 0,0, 1,0,8'h00, 0));
    seq2.push_back(mk(4'h1,0, 0,0,8'h00, 0,0, 1,0,8'h01, 0));

    rst_n          = 1'b0;
    thread_en      = 4'h0;
    hazard         = 1'b0;
    redirect_valid = 1'b0;
    redirect_tid   = 2'd0;
    redirect_pc    = 8'h00;
    halt_valid     = 1'b0;
    halt_tid       = 2'd0;

    repeat (2) @(negedge clk);
    chk("reset.valid", 32'(fetch_valid), 32'd0);
    chk("reset.tid",   32'(fetch_tid),   32'd0);
    chk("reset.pc",    32'(fetch_pc),    32'd0);
    chk("reset.done",  32'(all_done),    32'd0);
    rst_n = 1'b1;

    foreach (seq1[i]) run_vec(seq1[i], i);

    // Asynchronous reset between edges must clear outputs before any clock edge.
    thread_en = 4'hF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.valid", 32'(fetch_valid), 32'd0);
    chk("async_rst.tid",   32'(fetch_tid),   32'd0);
    chk("async_rst.pc",    32'(fetch_pc),    32'd0);
    chk("async_rst.done",  32'(all_done),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (seq2[i]) run_vec(seq2[i], 100 + i);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/thread_fetch_sched.md
# thread_fetch_sched

Fine-grained multithreaded fetch scheduler that sits ahead of the IF/ID stage register. It holds one program counter per hardware thread and issues one fetch per cycle, picking round-robin among enabled, non-halted threads. It stalls on pipeline hazards and accepts per-thread PC redirects (branch/jump) and halt notifications from later stages. Its registered outputs drive instruction-memory addressing and the IF/ID `PC_in` / `thread_id_in` inputs.

## Interface
- `INSTMEM_LOG2_DEEP`, default 8: PC width (W) in bits; instruction-memory depth is 2^W.
- `NUM_THREADS`, fixed 4: thread count; thread IDs are 2 bits.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RST_N` input 1: reset, asynchronous, active-low.
- `thread_en` input 4: per-thread enable mask; bit t=1 lets thread t be scheduled.
- `hazard` input 1: stall; freezes the outputs, the PCs and the RR pointer.
- `redirect_valid` input 1: load a new PC into thread `redirect_tid`.
- `redirect_tid` input 2: thread being redirected.
- `redirect_pc` input W: target PC for the redirect.
- `halt_valid` input 1: mark thread `halt_tid` halted.
- `halt_tid` input 2: thread being halted.
- `fetch_pc` output W: PC of the issued fetch.
- `fetch_tid` output 2: thread of the issued fetch.
- `fetch_valid` output 1: `fetch_pc` / `fetch_tid` hold a real fetch this cycle.
- `all_done` output 1: every enabled thread is halted, or no thread is enabled.

## Operation
- **State:**
  - `pc[0..3]` (W bits each).
  - `halted[3:0]`.
  - `last_tid[1:0]`: round-robin pointer.
  - Registered outputs.
- **Reset** (`RST_N`=0, async):
  - `pc[t]` = t·2^(W-2); threads start at quarter boundaries of instruction memory.
  - `halted` = 0; `last_tid` = 3, so thread 0 is issued first.
  - `fetch_pc` = 0, `fetch_tid` = 0, `fetch_valid` = 0.
- **Eligibility** (combinational):
  - `elig[t] = thread_en[t] & ~halted[t] & ~(halt_valid & halt_tid==t)`.
  - A halt arriving this cycle blocks selection of that thread this cycle.
- **Selection:** first eligible thread scanning `last_tid+1, +2, +3, +4` (mod 4). `last_tid` itself is selected only if it is the sole eligible thread.
- **Issue cycle** (`hazard`=0, some thread eligible; selected thread s):
  - Issued PC p = `redirect_pc` if `redirect_valid & redirect_tid==s` (same-cycle bypass); otherwise p = `pc[s]`.
  - Outputs: `fetch_pc` ← p, `fetch_tid` ← s, `fetch_valid` ← 1.
  - `pc[s]` ← p+1, truncated to W bits (2^W−1 wraps to 0). `last_tid` ← s.
- **Idle cycle** (`hazard`=0, no thread eligible):
  - `fetch_valid` ← 0; `fetch_pc` / `fetch_tid` hold.
  - `last_tid` holds.
- **Stall** (`hazard`=1):
  - `fetch_pc`, `fetch_tid`, `fetch_valid` and `last_tid` hold.
  - No PC increments.
- **Redirect:**
  - Applied every cycle it is valid, including during `hazard`: `pc[redirect_tid]` ← `redirect_pc`.
  - This overrides the increment for a thread that is not issued. For an issued thread the bypass rule above applies.
- **Halt:**
  - `halted[halt_tid]` ← 1, also during `hazard`. Only reset clears it.
  - Halt and redirect to the same thread in the same cycle: the PC is updated, the thread stays halted and is not issued.
- **`thread_en` changes:** take effect on the selection in the same cycle. A disabled thread keeps its PC and resumes from it when re-enabled.
- **`all_done`:** registered; equals `&(halted | ~thread_en)` as sampled in the previous cycle. Reset value is 0.

## Timing
- Latency: one cycle from a thread becoming eligible to `fetch_valid`=1 for it.
- Throughput: one fetch per cycle.
  - Four enabled threads: interleaved 0,1,2,3,0,…
  - One enabled thread: issues every cycle.
- Redirect with the target thread not issued that cycle: its next issue uses `redirect_pc`.
- Redirect with the target thread issued the same cycle: `fetch_pc` = `redirect_pc` on the following edge, with no bubble.
- Halt: the thread is never issued on or after the edge where `halt_valid` is sampled. A fetch already on the outputs is not retracted.
- `hazard` deasserted: scheduling resumes on that same edge from the held `last_tid`.
- Reset asserted mid-operation: all state returns immediately to reset values; the first fetch after `RST_N` rises is thread 0 at PC 0.

## Test plan
- **Reset and round-robin:** W=8, `thread_en`=1111, no hazard → (tid,pc) sequence (0,0),(1,64),(2,128),(3,192),(0,1),(1,65).
- **Masked threads:** `thread_en`=0101 → tids 0,2,0,2 with PCs 0,128,1,129. Then set `thread_en`=0 → `fetch_valid`=0, and `all_done`=1 one cycle later.
- **Stall:** assert `hazard` for 3 cycles mid-stream → outputs frozen. On release the next tid is the successor of the held tid, and no PC was skipped.
- **Redirect:**
  - Redirect thread 1 to 0x20 during `hazard` → thread 1's next issue is 0x20, then 0x21.
  - Redirect thread 2 to 0x50 in the cycle it is selected → `fetch_pc`=0x50 immediately, next issue of thread 2 is 0x51.
- **Halt:** halt thread 3 in its selection cycle → thread 3 is not issued, thread 0 is issued instead. Halt all threads → `fetch_valid`=0, `all_done`=1.
- **Wrap and async reset:**
  - `pc[0]`=0xFF → issues 0xFF, then 0x00.
  - Pull `RST_N` low between clock edges → outputs are 0 and `fetch_valid`=0 before the next edge.
